// File: rtl/commit_trace_serializer.sv
// commit_trace_serializer
//   Captures the two register-file write ports once per retired step, packs
//   each write into a record (header, key words, value words) and streams the
//   words over a valid/ready link to the DPI bridge.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   we1_i/wa1_i/wd1_i             write port 1 (enable, key, value)
//   we2_i/wa2_i/wd2_i             write port 2 (enable, key, value)
//   step_i                        this cycle's writes close the current step
//   in_ready_o                    at least two free record slots
//   word_o/word_valid_o           stream word and its valid
//   word_ready_i                  consumer accepts word
//   word_sop_o/word_eop_o         header word / last word of record
//   overflow_o                    sticky: records were dropped
module commit_trace_serializer #(
  parameter int unsigned DPI_WIDTH       = 32,
  parameter int unsigned KEY_WIDTH       = 64,
  parameter int unsigned VALUE_WIDTH     = 128,
  parameter int unsigned MAX_ENTRY_COUNT = 16,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   we1_i,
  input  logic [KEY_WIDTH-1:0]   wa1_i,
  input  logic [VALUE_WIDTH-1:0] wd1_i,
  input  logic                   we2_i,
  input  logic [KEY_WIDTH-1:0]   wa2_i,
  input  logic [VALUE_WIDTH-1:0] wd2_i,
  input  logic                   step_i,
  output logic                   in_ready_o,
  output logic [DPI_WIDTH-1:0]   word_o,
  output logic                   word_valid_o,
  input  logic                   word_ready_i,
  output logic                   word_sop_o,
  output logic                   word_eop_o,
  output logic                   overflow_o
);
  localparam int unsigned KW = KEY_WIDTH / DPI_WIDTH;
  localparam int unsigned VW = VALUE_WIDTH / DPI_WIDTH;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(MAX_ENTRY_COUNT + 1);
  localparam int unsigned WW = $clog2(((KW > VW) ? KW : VW) + 1);

  typedef struct packed {
    logic                   step_end;
    logic                   empty;
    logic [7:0]             idx;
    logic [KEY_WIDTH-1:0]   key;
    logic [VALUE_WIDTH-1:0] val;
  } rec_t;

  typedef enum logic [1:0] {IDLE, HDR, KEY, VAL} state_e;

  function automatic logic [DPI_WIDTH-1:0] hdr_word(input rec_t r);
    logic [DPI_WIDTH-1:0] h;
    h       = '0;
    h[0]    = r.step_end;
    h[1]    = r.empty;
    h[15:8] = r.idx;
    return h;
  endfunction

  rec_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [IW-1:0] idx_q;
  logic          ovf_q;

  // ---------------- record generation and admission ----------------
  rec_t          c0, c1;
  logic [1:0]    n;
  logic [CW-1:0] free;
  logic          fit, acc0, acc1, drop, pop;
  logic [IW-1:0] idx1;

  always_comb begin
    c0 = '0;
    c1 = '0;
    n  = 2'd0;
    if (we1_i && we2_i && (wa1_i == wa2_i)) begin
      c0.key = wa2_i; c0.val = wd2_i; n = 2'd1;
    end else if (we1_i && we2_i) begin
      c0.key = wa1_i; c0.val = wd1_i;
      c1.key = wa2_i; c1.val = wd2_i; n = 2'd2;
    end else if (we1_i) begin
      c0.key = wa1_i; c0.val = wd1_i; n = 2'd1;
    end else if (we2_i) begin
      c0.key = wa2_i; c0.val = wd2_i; n = 2'd1;
    end else if (step_i) begin
      c0.empty = 1'b1; n = 2'd1;
    end
    if (step_i) begin
      if (n == 2'd2) c1.step_end = 1'b1;
      else           c0.step_end = 1'b1;
    end
    free = CW'(FIFO_DEPTH) - count_q;
    fit  = free >= CW'(n);
    // A record rejected by the index limit leaves the index untouched, so the
    // second record inherits the same (already out-of-range) index.
    acc0 = (n != 2'd0) && fit && (idx_q < IW'(MAX_ENTRY_COUNT));
    idx1 = idx_q + IW'(acc0);
    acc1 = (n == 2'd2) && fit && (idx1 < IW'(MAX_ENTRY_COUNT));
    c0.idx = 8'(idx_q);
    c1.idx = 8'(idx1);
    drop = ((n != 2'd0) && !acc0) || ((n == 2'd2) && !acc1);
  end

  // ---------------- record FIFO ----------------
  always_ff @(posedge clk_i) begin
    if (acc0) mem_q[wr_ptr_q] <= c0;
    if (acc1) mem_q[wr_ptr_q + PW'(1)] <= c1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(acc0) + PW'(acc1);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count_q  <= count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
      idx_q    <= step_i ? '0 : (idx_q + IW'(acc0) + IW'(acc1));
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign in_ready_o = count_q <= CW'(FIFO_DEPTH - 2);
  assign overflow_o = ovf_q;

  // ---------------- output stream ----------------
  state_e                 state_q;
  logic [WW-1:0]          cnt_q, cnt_nx;
  logic [DPI_WIDTH-1:0]   word_q;
  logic                   valid_q, sop_q, eop_q, empty_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] val_q;
  logic                   xfer, ld_en;
  rec_t                   ld_rec;

  // The head record stays in the FIFO until its header is accepted; an empty
  // record that completes in HDR therefore takes its successor from head+1.
  always_comb begin
    xfer   = valid_q && word_ready_i;
    pop    = xfer && (state_q == HDR);
    cnt_nx = cnt_q + WW'(1);
    ld_en  = ((state_q == IDLE) && (count_q != '0)) ||
             (pop && empty_q && (count_q >= CW'(2))) ||
             (xfer && (state_q == VAL) && (cnt_q == WW'(VW - 1)) && (count_q != '0));
    ld_rec = (state_q == HDR) ? mem_q[rd_ptr_q + PW'(1)] : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= 1'b0;
      key_q   <= '0;
      val_q   <= '0;
    end else if (ld_en) begin
      state_q <= HDR;
      cnt_q   <= '0;
      word_q  <= hdr_word(ld_rec);
      valid_q <= 1'b1;
      sop_q   <= 1'b1;
      eop_q   <= ld_rec.empty;
      empty_q <= ld_rec.empty;
      key_q   <= ld_rec.key;
      val_q   <= ld_rec.val;
    end else if (xfer) begin
      unique case (state_q)
        HDR: begin
          if (empty_q) begin
            state_q <= IDLE; valid_q <= 1'b0; sop_q <= 1'b0; eop_q <= 1'b0; word_q <= '0;
          end else begin
            state_q <= KEY; cnt_q <= '0; word_q <= key_q[DPI_WIDTH-1:0];
            sop_q <= 1'b0; eop_q <= 1'b0;
          end
        end
        KEY: begin
          if (cnt_q == WW'(KW - 1)) begin
            state_q <= VAL; cnt_q <= '0; word_q <= val_q[DPI_WIDTH-1:0];
            eop_q <= (VW == 1);
          end else begin
            cnt_q  <= cnt_nx;
            word_q <= key_q[32'(cnt_nx) * DPI_WIDTH +: DPI_WIDTH];
          end
        end
        VAL: begin
          if (cnt_q == WW'(VW - 1)) begin
            state_q <= IDLE; valid_q <= 1'b0; sop_q <= 1'b0; eop_q <= 1'b0; word_q <= '0;
          end else begin
            cnt_q  <= cnt_nx;
            word_q <= val_q[32'(cnt_nx) * DPI_WIDTH +: DPI_WIDTH];
            eop_q  <= (cnt_nx == WW'(VW - 1));
          end
        end
        default: begin
          state_q <= IDLE; valid_q <= 1'b0; sop_q <= 1'b0; eop_q <= 1'b0; word_q <= '0;
        end
      endcase
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign word_sop_o   = sop_q;
  assign word_eop_o   = eop_q;

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Bench for commit_trace_serializer: reference model builds the expected word
// stream and buffer occupancy from the record rules; outputs are compared at
// every falling edge, plus literal expectations for the directed scenarios.
module tb_commit_trace_serializer;
  localparam int DW = 32, KWD = 64, VWD = 128, MAXE = 16, DEPTH = 8;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            we1 = 1'b0, we2 = 1'b0, step = 1'b0, rdy = 1'b0;
  logic [KWD-1:0]  wa1 = '0, wa2 = '0;
  logic [VWD-1:0]  wd1 = '0, wd2 = '0;
  logic            in_ready_o, word_valid_o, word_sop_o, word_eop_o, overflow_o;
  logic [DW-1:0]   word_o;

  always #5 clk = ~clk;

  commit_trace_serializer #(.DPI_WIDTH(DW), .KEY_WIDTH(KWD), .VALUE_WIDTH(VWD),
    .MAX_ENTRY_COUNT(MAXE), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
    .we2_i(we2), .wa2_i(wa2), .wd2_i(wd2),
    .step_i(step), .in_ready_o(in_ready_o),
    .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(rdy),
    .word_sop_o(word_sop_o), .word_eop_o(word_eop_o), .overflow_o(overflow_o));

  typedef logic [DW+1:0] ent_t;  // {sop, eop, word}
  ent_t exp_q[$];
  ent_t got_q[$];
  int   m_occ = 0, m_idx = 0;
  bit   m_ovf = 1'b0;
  int   errors = 0, checks = 0;
  bit   last_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic model_clear();
    exp_q.delete(); m_occ = 0; m_idx = 0; m_ovf = 1'b0;
  endtask

  // Expected behaviour of one input cycle, applied at the following clock edge.
  task automatic model_cycle(input bit e1, input logic [KWD-1:0] a1, input logic [VWD-1:0] d1,
                             input bit e2, input logic [KWD-1:0] a2, input logic [VWD-1:0] d2,
                             input bit st);
    logic [KWD-1:0] ks[2];
    logic [VWD-1:0] vs[2];
    logic [DW-1:0]  h;
    bit em;
    int n = 0;
    if (e1 && e2 && a1 == a2) begin ks[0] = a2; vs[0] = d2; n = 1; end
    else begin
      if (e1) begin ks[n] = a1; vs[n] = d1; n++; end
      if (e2) begin ks[n] = a2; vs[n] = d2; n++; end
    end
    em = (n == 0) && st;
    if (em) n = 1;
    if (n > 0) begin
      if (DEPTH - m_occ < n) m_ovf = 1'b1;
      else for (int i = 0; i < n; i++) begin
        if (m_idx >= MAXE) m_ovf = 1'b1;
        else begin
          h = DW'(m_idx * 256 + (em ? 2 : 0) + ((st && i == n - 1) ? 1 : 0));
          exp_q.push_back({1'b1, em, h});
          if (!em) begin
            for (int k = 0; k < KWD / DW; k++) exp_q.push_back({2'b00, ks[i][k*DW +: DW]});
            for (int k = 0; k < VWD / DW; k++)
              exp_q.push_back({1'b0, (k == VWD / DW - 1), vs[i][k*DW +: DW]});
          end
          m_idx++; m_occ++;
        end
      end
    end
    if (st) m_idx = 0;
  endtask

  task automatic cycle(input bit e1, input logic [KWD-1:0] a1, input logic [VWD-1:0] d1,
                       input bit e2, input logic [KWD-1:0] a2, input logic [VWD-1:0] d2,
                       input bit st, input bit r);
    bit   hs;
    ent_t e;
    @(negedge clk);
    last_valid = word_valid_o;
    chk("in_ready", in_ready_o, 64'((DEPTH - m_occ) >= 2));
    chk("overflow", overflow_o, 64'(m_ovf));
    if (word_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL word_unexpected: got %h expected no valid word", word_o);
      end else chk("word", {word_sop_o, word_eop_o, word_o}, exp_q[0]);
    end
    we1 = e1; wa1 = a1; wd1 = d1; we2 = e2; wa2 = a2; wd2 = d2; step = st; rdy = r;
    hs = word_valid_o && r && exp_q.size() > 0;
    if (hs) begin
      got_q.push_back({word_sop_o, word_eop_o, word_o});
      e = exp_q.pop_front();
    end
    model_cycle(e1, a1, d1, e2, a2, d2, st);
    if (hs && e[DW+1]) m_occ--;
  endtask

  task automatic idle(input bit r);
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, r);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) idle(1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    we1 = 1'b0; we2 = 1'b0; step = 1'b0; rdy = 1'b0;
    #1;
    model_clear();
    chk("rst_valid", word_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_overflow", overflow_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int sops;
    logic [DW-1:0] w_first;
    bit have;
    repeat (2) @(negedge clk);
    chk("rst_word", word_o, 0);
    chk("rst_sop", word_sop_o, 0);
    chk("rst_eop", word_eop_o, 0);
    do_reset();

    // single write closing a step, plus header latency
    got_q.delete();
    cycle(1'b1, 64'h5, 128'hA, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(1'b0);
    chk("latency_before", last_valid, 0);
    idle(1'b1);
    chk("latency_hdr", last_valid, 1);
    drain();
    chk("t1_len", 64'(got_q.size()), 7);
    if (got_q.size() == 7) begin
      chk("t1_hdr", got_q[0], {2'b10, 32'h1});
      chk("t1_key0", got_q[1], {2'b00, 32'h5});
      chk("t1_key1", got_q[2], {2'b00, 32'h0});
      chk("t1_val0", got_q[3], {2'b00, 32'hA});
      chk("t1_val3", got_q[6], {2'b01, 32'h0});
    end

    // two ports, one step
    got_q.delete();
    cycle(1'b1, 64'h3, 128'h11, 1'b1, 64'h7, 128'h22, 1'b1, 1'b1);
    drain();
    chk("t2_len", 64'(got_q.size()), 14);
    if (got_q.size() == 14) begin
      chk("t2_hdr0", got_q[0], {2'b10, 32'h0});
      chk("t2_key0", got_q[1], {2'b00, 32'h3});
      chk("t2_hdr1", got_q[7], {2'b10, 32'h101});
      chk("t2_key1", got_q[8], {2'b00, 32'h7});
    end

    // step with no writes
    got_q.delete();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    drain();
    chk("t4_len", 64'(got_q.size()), 1);
    if (got_q.size() == 1) chk("t4_hdr", got_q[0], {2'b11, 32'h3});

    // same address on both ports: port 2 wins, index restarted at 0
    got_q.delete();
    cycle(1'b1, 64'h9, 128'h1, 1'b1, 64'h9, 128'h2, 1'b0, 1'b1);
    drain();
    chk("t3_len", 64'(got_q.size()), 7);
    if (got_q.size() == 7) begin
      chk("t3_hdr", got_q[0], {2'b10, 32'h0});
      chk("t3_val0", got_q[3], {2'b00, 32'h2});
    end

    // consumer stalled while writing every cycle
    got_q.delete();
    have = 1'b0;
    w_first = '0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 64'(i + 32), 128'(i * 3 + 1), 1'b0, '0, '0, 1'b0, 1'b0);
      if (last_valid && !have) begin have = 1'b1; w_first = word_o; end
    end
    chk("stall_in_ready", in_ready_o, 0);
    chk("stall_overflow", overflow_o, 1);
    chk("stall_valid", word_valid_o, 1);
    chk("stall_stable", word_o, w_first);
    drain();
    chk("stall_len", 64'(got_q.size()), 56);

    // 17 writes in one step: index limit drops the last
    do_reset();
    got_q.delete();
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 64'(100 + i), 128'(i), 1'b0, '0, '0, (i == 16), 1'b1);
      repeat (8) idle(1'b1);
    end
    drain();
    sops = 0;
    foreach (got_q[i]) if (got_q[i][DW+1]) sops++;
    chk("t6_records", 64'(sops), 16);
    chk("t6_overflow", overflow_o, 1);
    if (got_q.size() >= 7) chk("t6_last_hdr", got_q[got_q.size() - 7], {2'b10, 32'h0F00});

    // asynchronous reset in the middle of a record
    cycle(1'b1, 64'h44, 128'h55, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    @(posedge clk);
    #1;
    chk("midrec_valid", word_valid_o, 1);
    chk("midrec_sop", word_sop_o, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", word_valid_o, 0);
    chk("arst_word", word_o, 0);
    chk("arst_sop", word_sop_o, 0);
    chk("arst_eop", word_eop_o, 0);
    chk("arst_overflow", overflow_o, 0);
    chk("arst_in_ready", in_ready_o, 1);
    model_clear();
    we1 = 1'b0; we2 = 1'b0; step = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 1) == 1, 64'($urandom_range(0, 3)),
            {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 1) == 1, 64'($urandom_range(0, 3)),
            {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
